// File: rtl/dmem_store_bridge_if.sv
// Core load/store port and MEMORY_TOP data port bundled for the store bridge.
// The bridge uses the slave view; the core/memory environment uses master.
interface dmem_store_bridge_if #(
  parameter int DWidth = 32
);
  logic              core_req_i;
  logic              core_write_i;
  logic [DWidth-1:0] core_addr_i;
  logic [DWidth-1:0] core_wdata_i;
  logic              core_gnt_o;
  logic              core_rvalid_o;
  logic [DWidth-1:0] core_rdata_o;
  logic              dmem_req_o;
  logic              dmem_write_o;
  logic [DWidth-1:0] dmem_addr_o;
  logic [DWidth-1:0] dmem_wdata_o;
  logic              dmem_ready_i;
  logic [DWidth-1:0] dmem_rdata_i;
  logic              sb_empty_o;
  logic [31:0]       stall_cnt_o;

  modport slave (
    input  core_req_i, core_write_i, core_addr_i, core_wdata_i,
    input  dmem_ready_i, dmem_rdata_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o,
    output dmem_req_o, dmem_write_o, dmem_addr_o, dmem_wdata_o,
    output sb_empty_o, stall_cnt_o
  );

  modport master (
    output core_req_i, core_write_i, core_addr_i, core_wdata_i,
    output dmem_ready_i, dmem_rdata_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o,
    input  dmem_req_o, dmem_write_o, dmem_addr_o, dmem_wdata_o,
    input  sb_empty_o, stall_cnt_o
  );
endinterface

// File: rtl/dmem_store_bridge.sv
// Core-to-dmem bridge with an in-order store buffer; loads wait for the buffer
// to drain, and a saturating counter tracks core stall cycles.
module dmem_store_bridge #(
  parameter int DWidth  = 32,
  parameter int SbDepth = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  dmem_store_bridge_if.slave bus
);
  localparam int PW = $clog2(SbDepth);

  typedef enum logic [1:0] {IDLE, STORE, LOAD} state_t;

  state_t            state, state_nxt;
  logic [PW:0]       count, count_nxt;
  logic [PW-1:0]     wptr, rptr;
  logic [DWidth-1:0] sb_addr [SbDepth];
  logic [DWidth-1:0] sb_data [SbDepth];
  logic [DWidth-1:0] ld_addr, rdata;
  logic              rvalid, sb_empty;
  logic [31:0]       stall_cnt;
  logic              store_gnt, load_gnt, gnt, pop;

  // Stores may queue behind a draining buffer but never behind a pending load.
  always_comb begin
    store_gnt = !rst_i && bus.core_req_i && bus.core_write_i &&
                (count < (PW+1)'(SbDepth)) && (state != LOAD);
    load_gnt  = !rst_i && bus.core_req_i && !bus.core_write_i &&
                (state == IDLE) && (count == '0);
    gnt       = store_gnt || load_gnt;
    pop       = (state == STORE) && bus.dmem_ready_i;
    count_nxt = count + (PW+1)'(store_gnt) - (PW+1)'(pop);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count_nxt != '0) state_nxt = STORE;
               else if (load_gnt)   state_nxt = LOAD;
      STORE:   if (pop && count_nxt == '0) state_nxt = IDLE;
      LOAD:    if (bus.dmem_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
      for (int i = 0; i < SbDepth; i++) begin
        sb_addr[i] <= '0;
        sb_data[i] <= '0;
      end
    end else begin
      count <= count_nxt;
      if (store_gnt) begin
        sb_addr[wptr] <= bus.core_addr_i;
        sb_data[wptr] <= bus.core_wdata_i;
        wptr          <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ld_addr   <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      sb_empty  <= 1'b1;
      stall_cnt <= '0;
    end else begin
      if (load_gnt) ld_addr <= bus.core_addr_i;
      rvalid <= (state == LOAD) && bus.dmem_ready_i;
      if ((state == LOAD) && bus.dmem_ready_i) rdata <= bus.dmem_rdata_i;
      sb_empty <= (count_nxt == '0);
      if (bus.core_req_i && !gnt && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.core_gnt_o    = gnt;
  assign bus.core_rvalid_o = rvalid;
  assign bus.core_rdata_o  = rdata;
  assign bus.dmem_req_o    = (state != IDLE);
  assign bus.dmem_write_o  = (state == STORE);
  assign bus.dmem_addr_o   = (state == STORE) ? sb_addr[rptr] : ld_addr;
  assign bus.dmem_wdata_o  = (state == STORE) ? sb_data[rptr] : '0;
  assign bus.sb_empty_o    = sb_empty;
  assign bus.stall_cnt_o   = stall_cnt;
endmodule

// File: tb/tb_dmem_store_bridge.sv
// Bench for dmem_store_bridge: directed scenarios plus random traffic, checked
// against a queue-based model of the store buffer and load ordering.
module tb_dmem_store_bridge;
  localparam int DW = 32;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_store_bridge_if #(.DWidth(DW)) bus ();
  dmem_store_bridge #(.DWidth(DW), .SbDepth(D)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } st_t;

  st_t         sbq[$];
  bit          ld_pend;
  logic [31:0] ld_a, m_stall, m_rdata;
  bit          m_rvalid;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] phys    [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] rd_phys(input logic [31:0] a);
    return phys.exists(a) ? phys[a] : init_val(a);
  endfunction

  task automatic model_reset();
    sbq.delete();
    ld_pend  = 1'b0;
    ld_a     = '0;
    m_stall  = '0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
  endtask

  task automatic check_regs();
    bit exp_req;
    exp_req = (sbq.size() > 0) || ld_pend;
    chk("dmem_req", bus.dmem_req_o, exp_req);
    if (exp_req) begin
      chk("dmem_write", bus.dmem_write_o, sbq.size() > 0);
      chk("dmem_addr", bus.dmem_addr_o, (sbq.size() > 0) ? sbq[0].a : ld_a);
      if (sbq.size() > 0) chk("dmem_wdata", bus.dmem_wdata_o, sbq[0].d);
    end
    chk("sb_empty", bus.sb_empty_o, sbq.size() == 0);
    chk("rvalid", bus.core_rvalid_o, m_rvalid);
    chk("rdata", bus.core_rdata_o, m_rdata);
    chk("stall_cnt", bus.stall_cnt_o, m_stall);
  endtask

  // One clock: drive at negedge, check grant, advance model, check registers.
  task automatic step(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input bit rdy, output bit g);
    bit exp_g;
    bus.core_req_i   = r;
    bus.core_write_i = w;
    bus.core_addr_i  = a;
    bus.core_wdata_i = d;
    bus.dmem_ready_i = rdy;
    bus.dmem_rdata_i = rd_phys(bus.dmem_addr_o);
    #1;
    exp_g = !rst && r && !ld_pend && (w ? (sbq.size() < D) : (sbq.size() == 0));
    chk("gnt", bus.core_gnt_o, exp_g);
    g = bus.core_gnt_o;
    if (bus.dmem_req_o && bus.dmem_write_o && rdy) phys[bus.dmem_addr_o] = bus.dmem_wdata_o;
    if (rst) model_reset();
    else begin
      st_t e;
      m_rvalid = 1'b0;
      if (ld_pend && rdy) begin
        m_rvalid = 1'b1;
        m_rdata  = rd_ref(ld_a);
        ld_pend  = 1'b0;
      end else if (sbq.size() > 0 && rdy) begin
        ref_mem[sbq[0].a] = sbq[0].d;
        void'(sbq.pop_front());
      end
      if (r && !exp_g && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (exp_g && w) begin
        e.a = a;
        e.d = d;
        sbq.push_back(e);
      end
      if (exp_g && !w) begin
        ld_pend = 1'b1;
        ld_a    = a;
      end
    end
    @(negedge clk);
    check_regs();
  endtask

  task automatic do_reset();
    bit g;
    rst = 1'b1;
    step(1'b0, 1'b0, '0, '0, 1'b0, g);
    step(1'b0, 1'b0, '0, '0, 1'b0, g);
    rst = 1'b0;
  endtask

  initial begin
    bit          g, pend, pw;
    logic [31:0] pa, pd;
    rst = 1'b1;
    bus.core_req_i = 1'b0; bus.core_write_i = 1'b0;
    bus.core_addr_i = '0;  bus.core_wdata_i = '0;
    bus.dmem_ready_i = 1'b0; bus.dmem_rdata_i = '0;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("rst.sb_empty", bus.sb_empty_o, 32'd1);
    chk("rst.dmem_req", bus.dmem_req_o, 32'd0);

    // Store then load to the same word: load waits for the buffer to drain.
    step(1'b1, 1'b1, 32'h4000, 32'hDEADBEEF, 1'b0, g);
    chk("t1.st_gnt", g, 32'd1);
    step(1'b1, 1'b0, 32'h4000, '0, 1'b0, g);
    chk("t1.ld_gnt_T1", g, 32'd0);
    step(1'b1, 1'b0, 32'h4000, '0, 1'b0, g);
    step(1'b1, 1'b0, 32'h4000, '0, 1'b1, g);
    chk("t1.ld_gnt_T3", g, 32'd0);
    step(1'b1, 1'b0, 32'h4000, '0, 1'b0, g);
    chk("t1.ld_gnt_T4", g, 32'd1);
    chk("t1.req_T5", bus.dmem_req_o, 32'd1);
    step(1'b0, 1'b0, '0, '0, 1'b1, g);
    chk("t1.rvalid", bus.core_rvalid_o, 32'd1);
    chk("t1.rdata", bus.core_rdata_o, 32'hDEADBEEF);
    chk("t1.stall", bus.stall_cnt_o, 32'd3);
    step(1'b0, 1'b0, '0, '0, 1'b0, g);

    // Fill the buffer with memory stalled; fifth store is held off.
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 32'h4000 + 32'(4*k), $urandom, 1'b0, g);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 32'h4010, 32'h1111_2222, 1'b0, g);
      chk("t2.addr", bus.dmem_addr_o, 32'h4000);
    end
    chk("t2.stall", bus.stall_cnt_o, 32'd6);

    // Counter saturation.
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    m_stall = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 32'h4010, 32'h1111_2222, 1'b0, g);
    chk("t6.stall_sat", bus.stall_cnt_o, 32'hFFFF_FFFF);

    // Drain one per cycle.
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, '0, '0, 1'b1, g);
    chk("t3.empty", bus.sb_empty_o, 32'd1);
    chk("t3.req_low", bus.dmem_req_o, 32'd0);

    // Steady push+pop at occupancy 3; pointers wrap.
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 32'h4000 + 32'(4*k), $urandom, 1'b0, g);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 32'h4100 + 32'(4*k), $urandom, 1'b1, g);
      chk("t4.push_gnt", g, 32'd1);
    end
    chk("t4.nonempty", bus.sb_empty_o, 32'd0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, '0, '0, 1'b1, g);

    // Reset in the middle of a load.
    do_reset();
    step(1'b1, 1'b0, 32'h4004, '0, 1'b0, g);
    chk("t5.ld_gnt", g, 32'd1);
    rst = 1'b1;
    bus.core_req_i = 1'b1;
    #1;
    chk("t5.req_drop", bus.dmem_req_o, 32'd0);
    chk("t5.gnt_rst", bus.core_gnt_o, 32'd0);
    step(1'b1, 1'b0, 32'h4004, '0, 1'b1, g);
    rst = 1'b0;
    step(1'b0, 1'b0, '0, '0, 1'b1, g);
    chk("t5.no_rvalid", bus.core_rvalid_o, 32'd0);
    chk("t5.stall0", bus.stall_cnt_o, 32'd0);
    chk("t5.empty", bus.sb_empty_o, 32'd1);

    // Random traffic; the core holds its request until granted.
    pend = 1'b0; pw = 1'b0; pa = '0; pd = '0;
    for (int c = 0; c < 2000; c++) begin
      if (!pend && ($urandom % 3 == 0)) begin
        pend = 1'b1;
        pw   = 1'($urandom % 2);
        pa   = 32'h4000 + 32'(4 * $urandom_range(0, 7));
        pd   = $urandom;
      end
      step(pend, pw, pa, pd, ($urandom % 3) != 0, g);
      if (g) pend = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_store_bridge.md
Name: dmem_store_bridge

Overview:
- Sits between the scalar core's load/store port and the MEMORY_TOP data port; owns the dmem req/ready handshake.
- Contains a small in-order store buffer, so the core retires stores without waiting on memory.
- Loads are strictly ordered behind buffered stores; a load is granted only when the buffer is empty.
- Exports a saturating stall-cycle counter used for the mcycle performance breakdown in MLP inference runs.

Parameters:
DWidth, 32, data/address width
SbDepth, 4, store-buffer entries; power of two, >= 2

Ports:
clk_i  input  1  core clock
rst_i  input  1  asynchronous reset, active-high
core_req_i  input  1  core access request; held until granted
core_write_i  input  1  1=store, 0=load
core_addr_i  input  DWidth  byte address, word-aligned
core_wdata_i  input  DWidth  store data
core_gnt_o  output  1  request accepted this cycle (combinational)
core_rvalid_o  output  1  one-cycle pulse, load data valid
core_rdata_o  output  DWidth  load data, registered
dmem_req_o  output  1  memory request
dmem_write_o  output  1  memory write enable
dmem_addr_o  output  DWidth  memory address
dmem_wdata_o  output  DWidth  memory write data
dmem_ready_i  input  1  memory completion pulse; read data valid in the same cycle
dmem_rdata_i  input  DWidth  memory read data
sb_empty_o  output  1  store buffer empty, registered
stall_cnt_o  output  32  cycles with core_req_i=1 and core_gnt_o=0

Behaviour:
- Reset (async, takes effect immediately):
  - State to IDLE; buffer cleared, contents discarded.
  - All outputs 0, except sb_empty_o=1.
  - dmem_req_o drops in the same cycle rst_i rises.
  - core_gnt_o is forced 0 while rst_i=1.
- FSM states: IDLE, STORE, LOAD.
  - dmem_req_o = (state != IDLE), driven from registers.
  - STORE: dmem_write_o=1; addr/wdata from the buffer head.
  - LOAD: dmem_write_o=0; addr from the latched load address.
- Store grant: core_gnt_o = core_req_i & core_write_i & (count < SbDepth) & (state != LOAD). The entry is pushed at that clock edge.
- Load grant: core_gnt_o = core_req_i & !core_write_i & (state == IDLE) & (count == 0). Address is latched; next state is LOAD.
- IDLE transitions: if the post-edge count > 0, go to STORE; else if a load is granted, go to LOAD; else stay IDLE.
- STORE: on dmem_ready_i, pop the head.
  - If the post-edge count (after pop and any same-cycle push) > 0, stay in STORE; dmem_req_o stays high and presents the new head next cycle.
  - Otherwise go to IDLE.
  - Without ready, all dmem outputs hold stable.
- LOAD: on dmem_ready_i, register dmem_rdata_i into core_rdata_o, pulse core_rvalid_o the next cycle, go to IDLE.
  - core_rdata_o holds its value until the next load completes.
- Latency:
  - Store granted at cycle T gives dmem_req_o at T+1.
  - Load granted at T gives dmem_req_o at T+1; with ready at T+k, core_rvalid_o is at T+k+1.
  - Back-to-back stores with ready every cycle drain one per cycle.
- Simultaneous push and pop: count unchanged. Read and write pointers wrap modulo SbDepth.
- Full (count == SbDepth): stores are not granted; the core holds its request.
- A load request while the buffer is non-empty, or while a load is outstanding, is not granted.
- dmem_ready_i while dmem_req_o=0 is ignored.
- stall_cnt_o increments by 1 each cycle core_req_i=1 & core_gnt_o=0; saturates at 0xFFFFFFFF.
- sb_empty_o = (count == 0) after each edge.

Test Plan:
1. Store 0x00004000/0xDEADBEEF at T0, ready at T3; then a load of 0x00004000 requested at T1 -> load gnt=0 through T3 (buffer non-empty), granted T4, req at T5; ready at T5 with rdata 0xDEADBEEF -> rvalid=1 at T6 with rdata 0xDEADBEEF; stall_cnt_o=3.
2. Four stores 0x4000..0x400C, ready held 0 -> 5th store gnt=0 for 6 cycles, stall_cnt_o=6; dmem_addr_o stays 0x4000 throughout.
3. Four buffered stores, then ready=1 continuously -> four consecutive req cycles with addrs 0x4000, 0x4004, 0x4008, 0x400C; req drops the next cycle; sb_empty_o=1.
4. Count=3, push and pop in the same cycle, repeated 6 times -> count stays 3; pointers wrap; memory receives data in exact push order.
5. rst_i asserted mid-LOAD -> dmem_req_o=0 immediately; rvalid never pulses; post-reset sb_empty_o=1, stall_cnt_o=0.
6. stall_cnt preloaded via force to 0xFFFFFFFE, 3 stall cycles -> stall_cnt_o=0xFFFFFFFF, no wrap.
